serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor : bit-serial D = A - B - Bin, LSB first, registered borrow
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic             diff_bit;
  logic             borrow_nxt;
  logic             last_bit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Full-subtractor cell
  always_comb begin
    diff_bit   = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    borrow_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & borrow_q) | (b_sr_q[0] & borrow_q);
    last_bit   = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    v_d      = v_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d   = A;
          b_sr_d   = B;
          borrow_d = Bin;
          cnt_d    = '0;
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = {diff_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CW'(1);
        // Visible results update only once the final bit is in.
        if (last_bit) begin
          d_d    = {diff_bit, res_q[WIDTH-1:1]};
          bout_d = borrow_nxt;
          v_d    = (a_msb_q ^ b_msb_q) & (diff_bit ^ a_msb_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor : directed self-checking bench for serial_subtractor
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] prev_d;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive operands and start; returns at #1 after the accepting edge (T0).
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at #1 after T0; ends at #1 after T(WIDTH+1).
  task automatic finish_op(input string tag, input logic [WIDTH-1:0] ed,
                           input logic eb, input logic ev);
    int busy_cnt = 0;
    int bad      = 0;
    check_eq({tag, "_held_d"}, 32'(D), 32'(prev_d));
    for (int k = 0; k < WIDTH; k++) begin
      if (busy) busy_cnt++;
      if (done) bad++;
      @(posedge clk); #1;
    end
    check_eq({tag, "_busy_cycles"}, busy_cnt, WIDTH);
    check_eq({tag, "_early_done"}, bad, 0);
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_busy_at_done"}, 32'(busy), 0);
    check_eq({tag, "_d"}, 32'(D), 32'(ed));
    check_eq({tag, "_bout"}, 32'(Bout), 32'(eb));
    check_eq({tag, "_v"}, 32'(V), 32'(ev));
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 0);
    check_eq({tag, "_hold_d"}, 32'(D), 32'(ed));
    prev_d = ed;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    Bin    = 1'b0;
    prev_d = '0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_d",    32'(D), 0);
    check_eq("rst_bout", 32'(Bout), 0);
    check_eq("rst_v",    32'(V), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'h5A, 8'h13, 1'b0);  finish_op("op5a_13", 8'h47, 1'b0, 1'b0);
    issue(8'h00, 8'h01, 1'b0);  finish_op("op00_01", 8'hFF, 1'b1, 1'b0);
    issue(8'h80, 8'h01, 1'b0);  finish_op("op80_01", 8'h7F, 1'b0, 1'b1);
    issue(8'h7F, 8'hFF, 1'b0);  finish_op("op7f_ff", 8'h80, 1'b1, 1'b1);
    issue(8'h10, 8'h0F, 1'b1);  finish_op("op10_0f_b", 8'h00, 1'b0, 1'b0);

    // Start and operand changes during RUN must be ignored.
    issue(8'h05, 8'h03, 1'b0);
    check_eq("ign_held_d", 32'(D), 32'(prev_d));
    A = 8'hC3; B = 8'h3C; Bin = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; A = 8'hFF; B = 8'h00;
    @(posedge clk); #1;
    check_eq("ign_busy_t3", 32'(busy), 1);
    start = 1'b0; A = 8'h11; Bin = 1'b0;
    for (int k = 4; k <= WIDTH; k++) begin
      @(posedge clk); #1;
    end
    check_eq("ign_done", 32'(done), 1);
    check_eq("ign_d",    32'(D), 32'h02);
    check_eq("ign_bout", 32'(Bout), 0);
    check_eq("ign_v",    32'(V), 0);
    prev_d = 8'h02;
    A = 8'h09; B = 8'h04; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check_eq("t9_not_accepted", 32'(busy), 0);
    check_eq("t9_done_low", 32'(done), 0);
    @(posedge clk); #1;
    check_eq("t10_accepted", 32'(busy), 1);
    start = 1'b0;
    finish_op("op09_04", 8'h05, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation.
    issue(8'h5A, 8'h13, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_d",    32'(D), 0);
    check_eq("abort_bout", 32'(Bout), 0);
    check_eq("abort_v",    32'(V), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_eq("abort_no_done", 32'(done), 0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    prev_d = '0;
    issue(8'h33, 8'h11, 1'b0);  finish_op("op33_11", 8'h22, 1'b0, 1'b0);

    // Back-to-back with start held high: accepts every WIDTH+2 cycles.
    A = 8'h20; B = 8'h05; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b0_accept", 32'(busy), 1);
    A = 8'h05; B = 8'h20; Bin = 1'b0;
    finish_op("b2b0", 8'h1B, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("b2b1_accept", 32'(busy), 1);
    A = 8'h80; B = 8'h7F; Bin = 1'b1;
    finish_op("b2b1", 8'hE5, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_eq("b2b2_accept", 32'(busy), 1);
    finish_op("b2b2", 8'h00, 1'b0, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
